// File: rtl/sy_dpram_fifo_pkg.sv
// Shared definitions for the dual-port-RAM FIFO controller: default geometry,
// the registered flag bundle and the pointer-pair occupancy function.
package sy_dpram_fifo_pkg;

  localparam int DEF_WD    = 8;
  localparam int DEF_AD    = 4;
  localparam int DEF_DP    = 2 ** DEF_AD;
  localparam int DEF_PTR_W = DEF_AD + 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Occupancy from a pointer pair of width ad+1; wraps modulo 2**(ad+1).
  function automatic int unsigned ptr_count(input int unsigned wp,
                                            input int unsigned rp,
                                            input int unsigned ad);
    int unsigned mask;
    mask = (32'd1 << (ad + 1)) - 32'd1;
    return (wp - rp) & mask;
  endfunction

endpackage

// File: rtl/sy_dpram_fifo_if.sv
// Push/pop stream interface of the FIFO: requests, pop data and status flags.
interface sy_dpram_fifo_if
  import sy_dpram_fifo_pkg::*;
#(
  parameter int WD = DEF_WD,
  parameter int AD = DEF_AD
);

  logic          clr;
  logic          wr_en;
  logic [WD-1:0] wr_data;
  logic          rd_en;
  logic [WD-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AD:0]   count;
  logic          ovf;
  logic          udf;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, ovf, udf
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, ovf, udf
  );

endinterface

// File: rtl/sy_fifo_ptr.sv
// Pointer, occupancy and flag engine of the FIFO. Accept decisions use the
// registered flags; every status output is registered on the accepting edge.
module sy_fifo_ptr
  import sy_dpram_fifo_pkg::*;
#(
  parameter int AD    = DEF_AD,
  parameter int AF_TH = 2 ** AD - 2,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AD-1:0] wr_addr,
  output logic [AD-1:0] rd_addr,
  output logic [AD:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ovf,
  output logic          udf
);

  localparam int           PW    = AD + 1;
  localparam logic [AD:0]  ONE   = {{AD{1'b0}}, 1'b1};
  localparam logic [AD:0]  AF_C  = PW'(AF_TH);
  localparam logic [AD:0]  AE_C  = PW'(AE_TH);
  localparam fifo_flags_t  FLG_RST = '{full: 1'b0, empty: 1'b1,
                                       almost_full: (AF_TH <= 0),
                                       almost_empty: 1'b1};

  logic [AD:0] wr_ptr, rd_ptr;
  logic [AD:0] wp_nxt, rp_nxt, cnt_nxt;
  fifo_flags_t flg_q, flg_nxt;

  // A flush in the same cycle swallows both requests without touching RAM.
  assign wr_ok = wr_en & ~flg_q.full  & ~clr;
  assign rd_ok = rd_en & ~flg_q.empty & ~clr;

  always_comb begin
    wp_nxt  = wr_ptr + {{AD{1'b0}}, wr_ok};
    rp_nxt  = rd_ptr + {{AD{1'b0}}, rd_ok};
    cnt_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = count + ONE;
      2'b01:   cnt_nxt = count - ONE;
      default: cnt_nxt = count;
    endcase
    flg_nxt.full         = (wp_nxt[AD] != rp_nxt[AD]) &&
                           (wp_nxt[AD-1:0] == rp_nxt[AD-1:0]);
    flg_nxt.empty        = (wp_nxt == rp_nxt);
    flg_nxt.almost_full  = (cnt_nxt >= AF_C);
    flg_nxt.almost_empty = (cnt_nxt <= AE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flg_q  <= FLG_RST;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flg_q  <= FLG_RST;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wp_nxt;
      rd_ptr <= rp_nxt;
      count  <= cnt_nxt;
      flg_q  <= flg_nxt;
      if (wr_en && flg_q.full)  ovf <= 1'b1;
      if (rd_en && flg_q.empty) udf <= 1'b1;
    end
  end

  assign wr_addr      = wr_ptr[AD-1:0];
  assign rd_addr      = rd_ptr[AD-1:0];
  assign full         = flg_q.full;
  assign empty        = flg_q.empty;
  assign almost_full  = flg_q.almost_full;
  assign almost_empty = flg_q.almost_empty;

  // The up/down counter must always agree with the pointer difference.
  logic [AD:0] ptr_diff;
  assign ptr_diff = PW'(ptr_count(32'(wr_ptr), 32'(rd_ptr), AD));

  a_count_matches_ptrs: assert property (
    @(posedge clk) disable iff (!rst_n) ptr_diff == count
  );

endmodule

// File: rtl/sy_dpram_fifo.sv
// FIFO controller in front of a true dual-port RAM: port A writes, port B reads,
// pop data comes straight from the RAM's registered port B output.
module sy_dpram_fifo
  import sy_dpram_fifo_pkg::*;
#(
  parameter int WD    = DEF_WD,
  parameter int AD    = DEF_AD,
  parameter int AF_TH = 2 ** AD - 2,
  parameter int AE_TH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sy_dpram_fifo_if.slave      fif,
  output logic                ram_cs_n,
  output logic                ram_aw_r_n,
  output logic [AD-1:0]       ram_addr_a,
  output logic [WD-1:0]       ram_din_a,
  output logic                ram_bw_r_n,
  output logic [AD-1:0]       ram_addr_b,
  input  logic [WD-1:0]       ram_dout_b
);

  logic          wr_ok, rd_ok;
  logic [AD-1:0] wr_addr, rd_addr;
  logic          rd_vld_p1;

  sy_fifo_ptr #(
    .AD    (AD),
    .AF_TH (AF_TH),
    .AE_TH (AE_TH)
  ) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (fif.clr),
    .wr_en        (fif.wr_en),
    .rd_en        (fif.rd_en),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (fif.count),
    .full         (fif.full),
    .empty        (fif.empty),
    .almost_full  (fif.almost_full),
    .almost_empty (fif.almost_empty),
    .ovf          (fif.ovf),
    .udf          (fif.udf)
  );

  // Chip select follows reset directly so the first edge after release can write.
  assign ram_cs_n   = ~rst_n;
  assign ram_aw_r_n = wr_ok;
  assign ram_addr_a = wr_addr;
  assign ram_din_a  = fif.wr_data;
  assign ram_bw_r_n = 1'b0;
  assign ram_addr_b = rd_addr;

  // Stage p1: RAM latches the popped word on the same edge that registers rd_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_vld_p1 <= 1'b0;
    else if (fif.clr) rd_vld_p1 <= 1'b0;
    else              rd_vld_p1 <= rd_ok;
  end

  assign fif.rd_valid = rd_vld_p1;
  assign fif.rd_data  = ram_dout_b;

endmodule

// File: tb/tb_sy_dpram_fifo.sv
// Directed bench for sy_dpram_fifo with a behavioural registered dual-port RAM.
module tb_sy_dpram_fifo;
  import sy_dpram_fifo_pkg::*;

  localparam int WD = 8;
  localparam int AD = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_cs_n, ram_aw_r_n, ram_bw_r_n;
  logic [AD-1:0] ram_addr_a, ram_addr_b;
  logic [WD-1:0] ram_din_a, ram_dout_b;
  logic [WD-1:0] mem [DP];

  int checks   = 0;
  int failures = 0;

  sy_dpram_fifo_if #(.WD(WD), .AD(AD)) bus ();

  sy_dpram_fifo #(.WD(WD), .AD(AD), .AF_TH(DP - 2), .AE_TH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fif        (bus),
    .ram_cs_n   (ram_cs_n),
    .ram_aw_r_n (ram_aw_r_n),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_bw_r_n (ram_bw_r_n),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (ram_aw_r_n) mem[ram_addr_a] <= ram_din_a;
      if (!ram_bw_r_n) ram_dout_b <= mem[ram_addr_b];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
  endtask

  task automatic clr_pulse();
    drive(1'b0, 8'h00, 1'b0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
         bus.ovf, bus.udf, bus.rd_valid, ram_cs_n} !== {5'd0, 8'b11000001}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b",
               {bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
                bus.ovf, bus.udf, bus.rd_valid, ram_cs_n}, {5'd0, 8'b11000001});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ram_cs_n, ram_bw_r_n} !== 2'b00) begin
      failures++;
      $display("FAIL cs_after_release got=%b exp=00", {ram_cs_n, ram_bw_r_n});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      #1;
      checks++;
      if ({ram_aw_r_n, ram_addr_a, ram_din_a} !== {1'b1, 4'(i), 8'(i)}) begin
        failures++;
        $display("FAIL fill_port_a i=%0d got=%h exp=%h", i,
                 {ram_aw_r_n, ram_addr_a, ram_din_a}, {1'b1, 4'(i), 8'(i)});
      end
      tick();
      checks++;
      if (bus.count !== 5'(i + 1) || bus.full !== (i == 15) ||
          bus.almost_full !== (i + 1 >= 14) || bus.empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_flags i=%0d count=%0d full=%b af=%b empty=%b", i,
                 bus.count, bus.full, bus.almost_full, bus.empty);
      end
    end
    drive(1'b1, 8'hAA, 1'b0);
    #1;
    checks++;
    if (ram_aw_r_n !== 1'b0) begin
      failures++;
      $display("FAIL fill_reject_write got=%b exp=0", ram_aw_r_n);
    end
    tick();
    checks++;
    if ({bus.ovf, bus.full, bus.count} !== {1'b1, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL fill_overflow ovf=%b full=%b count=%0d exp ovf=1 full=1 count=16",
               bus.ovf, bus.full, bus.count);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_drain();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_idle_valid got=%b exp=0", bus.rd_valid);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i) || bus.count !== 5'(15 - i) ||
          bus.empty !== (i == 15) || bus.almost_empty !== (15 - i <= 2)) begin
        failures++;
        $display("FAIL drain i=%0d vld=%b data=%h exp=%h count=%0d empty=%b ae=%b", i,
                 bus.rd_valid, bus.rd_data, 8'(i), bus.count, bus.empty, bus.almost_empty);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++;
    if ({bus.udf, bus.rd_valid, bus.count, bus.ovf} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL drain_underflow udf=%b vld=%b count=%0d ovf=%b exp 1 0 0 1",
               bus.udf, bus.rd_valid, bus.count, bus.ovf);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d, exp;
    int wp = 0, rp = 0, pushed = 0, step = 0;
    logic w, r;
    clr_pulse();
    for (int i = 0; i < 4; i++) begin
      d = 8'(pushed * 13 + 5);
      drive(1'b1, d, 1'b0);
      tick();
      q.push_back(d);
      wp++;
      pushed++;
    end
    for (int c = 0; c < 200 && (pushed < 40 || q.size() > 0); c++) begin
      if (pushed < 40) begin
        case (step % 5)
          0:       begin w = 1'b1; r = 1'b1; end
          1:       begin w = 1'b1; r = 1'b0; end
          2, 3:    begin w = 1'b0; r = 1'b1; end
          default: begin w = 1'b1; r = 1'b0; end
        endcase
      end else begin
        w = 1'b0;
        r = 1'b1;
      end
      d = 8'(pushed * 13 + 5);
      drive(w, d, r);
      tick();
      if (r) begin
        exp = q.pop_front();
        rp++;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
          failures++;
          $display("FAIL wrap_data step=%0d vld=%b got=%h exp=%h", step,
                   bus.rd_valid, bus.rd_data, exp);
        end
      end
      if (w) begin
        q.push_back(d);
        wp++;
        pushed++;
      end
      checks++;
      if (bus.count !== 5'(ptr_count(wp, rp, AD))) begin
        failures++;
        $display("FAIL wrap_count step=%0d got=%0d exp=%0d", step, bus.count,
                 ptr_count(wp, rp, AD));
      end
      step++;
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (pushed != 40 || q.size() != 0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done pushed=%0d left=%0d empty=%b exp 40 0 1",
               pushed, q.size(), bus.empty);
    end
  endtask

  task automatic test_simultaneous();
    clr_pulse();
    push_n(5, 8'h50);
    drive(1'b1, 8'h55, 1'b1);
    tick();
    checks++;
    if ({bus.count, bus.rd_valid, bus.rd_data} !== {5'd5, 1'b1, 8'h50}) begin
      failures++;
      $display("FAIL simul_mid count=%0d vld=%b data=%h exp 5 1 50",
               bus.count, bus.rd_valid, bus.rd_data);
    end
    clr_pulse();
    drive(1'b1, 8'h60, 1'b1);
    tick();
    checks++;
    if ({bus.count, bus.udf, bus.rd_valid, bus.empty} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL simul_empty count=%0d udf=%b vld=%b empty=%b exp 1 1 0 0",
               bus.count, bus.udf, bus.rd_valid, bus.empty);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h60}) begin
      failures++;
      $display("FAIL simul_empty_pop vld=%b data=%h exp 1 60", bus.rd_valid, bus.rd_data);
    end
    clr_pulse();
    push_n(16, 8'h70);
    drive(1'b1, 8'hEE, 1'b1);
    tick();
    checks++;
    if ({bus.count, bus.ovf, bus.full, bus.almost_full, bus.rd_valid, bus.rd_data} !==
        {5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 8'h70}) begin
      failures++;
      $display("FAIL simul_full count=%0d ovf=%b full=%b af=%b vld=%b data=%h exp 15 1 0 1 1 70",
               bus.count, bus.ovf, bus.full, bus.almost_full, bus.rd_valid, bus.rd_data);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_clr();
    clr_pulse();
    checks++;
    if ({bus.ovf, bus.udf, bus.count} !== {1'b0, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL clr_flush ovf=%b udf=%b count=%0d exp 0 0 0", bus.ovf, bus.udf, bus.count);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    push_n(7, 8'h80);
    drive(1'b1, 8'h87, 1'b1);
    tick();
    checks++;
    if ({bus.count, bus.rd_valid, bus.udf} !== {5'd7, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL clr_setup count=%0d vld=%b udf=%b exp 7 1 1", bus.count, bus.rd_valid, bus.udf);
    end
    bus.clr = 1'b1;
    drive(1'b1, 8'h99, 1'b1);
    #1;
    checks++;
    if (ram_aw_r_n !== 1'b0) begin
      failures++;
      $display("FAIL clr_drop_write got=%b exp=0", ram_aw_r_n);
    end
    tick();
    checks++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.ovf, bus.udf, bus.rd_valid} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_result count=%0d empty=%b ae=%b full=%b ovf=%b udf=%b vld=%b",
               bus.count, bus.empty, bus.almost_empty, bus.full, bus.ovf, bus.udf, bus.rd_valid);
    end
    bus.clr = 1'b0;
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++;
    if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 8'h3C, 5'd0}) begin
      failures++;
      $display("FAIL clr_resume vld=%b data=%h count=%0d exp 1 3c 0",
               bus.rd_valid, bus.rd_data, bus.count);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    clr_pulse();
    push_n(9, 8'h90);
    drive(1'b1, 8'h99, 1'b1);
    tick();
    checks++;
    if ({bus.count, bus.rd_valid} !== {5'd9, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_setup count=%0d vld=%b exp 9 1", bus.count, bus.rd_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
         bus.ovf, bus.udf, bus.rd_valid, ram_cs_n} !== {5'd0, 8'b11000001}) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=%b",
               {bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
                bus.ovf, bus.udf, bus.rd_valid, ram_cs_n}, {5'd0, 8'b11000001});
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    drive(1'b1, 8'hA5, 1'b0);
    tick();
    checks++;
    if ({bus.count, bus.empty, ram_cs_n} !== {5'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_push count=%0d empty=%b cs_n=%b exp 1 0 0",
               bus.count, bus.empty, ram_cs_n);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++;
    if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 8'hA5, 5'd0}) begin
      failures++;
      $display("FAIL rstmid_pop vld=%b data=%h count=%0d exp 1 a5 0",
               bus.rd_valid, bus.rd_data, bus.count);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
